// File: rtl/snow64_instr_fetch.sv
// Instruction fetch front end: PC sequencing, single-outstanding icache reads,
// and a small instruction/PC FIFO toward decode with redirect flush.
module snow64_instr_fetch #(
    parameter int                     WIDTH__ADDR  = 64,
    parameter int                     WIDTH__INSTR = 32,
    parameter int                     DEPTH        = 4,
    parameter logic [WIDTH__ADDR-1:0] RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    ic_req,
    output logic [WIDTH__ADDR-1:0]  ic_addr,
    input  logic                    ic_valid,
    input  logic [WIDTH__INSTR-1:0] ic_instr,
    input  logic                    redirect_valid,
    input  logic [WIDTH__ADDR-1:0]  redirect_pc,
    output logic                    out_valid,
    output logic [WIDTH__INSTR-1:0] out_instr,
    output logic [WIDTH__ADDR-1:0]  out_pc,
    input  logic                    out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StWaitDrop
    } state_t;

    state_t                  state;
    logic [WIDTH__ADDR-1:0]  pc;
    logic [WIDTH__ADDR-1:0]  req_pc;
    logic [WIDTH__INSTR-1:0] mem_instr [DEPTH];
    logic [WIDTH__ADDR-1:0]  mem_pc    [DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CNT_W-1:0]        count;

    logic [WIDTH__ADDR-1:0]  target;
    logic                    not_full;
    logic                    push;
    logic                    deq;

    assign target    = redirect_pc & ~WIDTH__ADDR'(3);
    assign not_full  = count < CNT_W'(DEPTH);
    assign out_valid = (count != '0) && !redirect_valid;
    assign deq       = out_valid && out_ready;
    assign push      = (state == StWait) && ic_valid && !redirect_valid;
    assign out_instr = mem_instr[head];
    assign out_pc    = mem_pc[head];

    // Storage has no reset; out_valid gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[tail] <= ic_instr;
            mem_pc[tail]    <= req_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            pc      <= RESET_PC;
            req_pc  <= '0;
            ic_req  <= 1'b0;
            ic_addr <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            ic_req <= 1'b0;

            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (deq)  head <= head + PTR_W'(1);
                if (push && !deq)      count <= count + CNT_W'(1);
                else if (deq && !push) count <= count - CNT_W'(1);
            end

            case (state)
                StIdle: begin
                    if (redirect_valid) begin
                        pc <= target;
                    end else if (not_full) begin
                        ic_req  <= 1'b1;
                        ic_addr <= pc;
                        req_pc  <= pc;
                        pc      <= pc + WIDTH__ADDR'(4);
                        state   <= StWait;
                    end
                end
                StWait: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        state <= ic_valid ? StIdle : StWaitDrop;
                    end else if (ic_valid) begin
                        state <= StIdle;
                    end
                end
                StWaitDrop: begin
                    if (redirect_valid) pc <= target;
                    if (ic_valid)       state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_snow64_instr_fetch.sv
// Randomized bench for snow64_instr_fetch against a transaction-level model
// (pending request flag, drop flag, and a queue of {instr, pc}).
module tb_snow64_instr_fetch;

    localparam int            AW       = 64;
    localparam int            IW       = 32;
    localparam int            DEPTH    = 4;
    localparam logic [AW-1:0] RESET_PC = 64'h0;

    logic          clk            = 1'b0;
    logic          rst_n          = 1'b0;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_valid       = 1'b0;
    logic [IW-1:0] ic_instr       = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc    = '0;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          out_ready      = 1'b0;

    snow64_instr_fetch #(
        .WIDTH__ADDR (AW),
        .WIDTH__INSTR(IW),
        .DEPTH       (DEPTH),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ic_req        (ic_req),
        .ic_addr       (ic_addr),
        .ic_valid      (ic_valid),
        .ic_instr      (ic_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [AW-1:0]    m_pc, m_req_pc, m_addr;
    logic             m_req, m_pending, m_drop;
    logic [AW+IW-1:0] m_q[$];

    int            ic_cnt, lat_min, lat_max, rdy_pct, redir_pct;
    logic [AW-1:0] redir_base, arm_pc;
    logic          arm_on_iv, arm_on_req;
    logic [AW-1:0] addr_log[$];
    logic [AW-1:0] pc_log[$];

    task automatic check_val(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] log_at(input logic [AW-1:0] q[$], input int i);
        return (i < q.size()) ? q[i] : '1;
    endfunction

    function automatic void model_reset();
        m_pc      = RESET_PC;
        m_req_pc  = '0;
        m_addr    = '0;
        m_req     = 1'b0;
        m_pending = 1'b0;
        m_drop    = 1'b0;
        m_q.delete();
        ic_cnt    = 0;
    endfunction

    // Predict the effect of the coming clock edge from the inputs now applied.
    function automatic void model_step();
        logic             do_push, do_deq;
        logic [AW+IW-1:0] entry;
        do_deq  = (m_q.size() != 0) && !redirect_valid && out_ready;
        do_push = 1'b0;
        entry   = {ic_instr, m_req_pc};
        m_req   = 1'b0;
        if (!m_pending) begin
            if (redirect_valid) begin
                m_pc = redirect_pc & ~64'h3;
            end else if (m_q.size() < DEPTH) begin
                m_req     = 1'b1;
                m_addr    = m_pc;
                m_req_pc  = m_pc;
                m_pc      = m_pc + 64'd4;
                m_pending = 1'b1;
                m_drop    = 1'b0;
            end
        end else begin
            if (ic_valid) begin
                m_pending = 1'b0;
                do_push   = !m_drop && !redirect_valid;
            end
            if (redirect_valid) begin
                m_pc = redirect_pc & ~64'h3;
                if (!ic_valid) m_drop = 1'b1;
            end
        end
        if (redirect_valid) begin
            m_q.delete();
        end else begin
            if (do_deq)  void'(m_q.pop_front());
            if (do_push) m_q.push_back(entry);
        end
    endfunction

    task automatic step();
        logic exp_ov;
        @(posedge clk);
        #1;
        check_val("ic_req", ic_req, m_req);
        check_val("ic_addr", ic_addr, m_addr);
        if (ic_req) addr_log.push_back(ic_addr);

        ic_valid       = 1'b0;
        redirect_valid = 1'b0;
        ic_instr       = $urandom;
        if (ic_req) begin
            ic_cnt = $urandom_range(lat_max, lat_min);
        end else if (ic_cnt > 0) begin
            ic_cnt--;
            ic_valid = (ic_cnt == 0);
        end
        if ($urandom_range(99, 0) < redir_pct) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_base + 64'($urandom_range(31, 0));
        end
        if (arm_on_req && ic_req) begin
            redirect_valid = 1'b1;
            redirect_pc    = arm_pc;
            arm_on_req     = 1'b0;
        end
        if (arm_on_iv && ic_valid) begin
            redirect_valid = 1'b1;
            redirect_pc    = arm_pc;
            arm_on_iv      = 1'b0;
        end
        out_ready = ($urandom_range(99, 0) < rdy_pct);
        #1;
        exp_ov = (m_q.size() != 0) && !redirect_valid;
        check_val("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            check_val("out_pc", out_pc, m_q[0][AW-1:0]);
            check_val("out_instr", out_instr, 64'(m_q[0][AW+IW-1:AW]));
        end
        if (out_valid && out_ready) pc_log.push_back(out_pc);
        model_step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_reqs(input int n, input int bound);
        for (int i = 0; i < bound && addr_log.size() < n; i++) step();
        check_val("wait_reqs", 64'(addr_log.size() >= n), 64'd1);
    endtask

    // Asynchronous reset pulse away from the clock edge; icache model resets too.
    task automatic do_reset();
        @(posedge clk);
        #2;
        ic_valid       = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        rst_n          = 1'b0;
        #1;
        check_val("rst_ic_req", ic_req, 64'd0);
        check_val("rst_ic_addr", ic_addr, 64'd0);
        check_val("rst_out_valid", out_valid, 64'd0);
        model_reset();
        addr_log.delete();
        pc_log.delete();
        #3;
        rst_n = 1'b1;
        model_step();
    endtask

    initial begin
        model_reset();
        lat_min = 1; lat_max = 1; rdy_pct = 100; redir_pct = 0;
        arm_on_iv = 1'b0; arm_on_req = 1'b0; arm_pc = '0; redir_base = '0;

        // Power-on reset and straight-line fetch with 1-cycle hits.
        #12;
        check_val("por_ic_req", ic_req, 64'd0);
        check_val("por_ic_addr", ic_addr, 64'd0);
        check_val("por_out_valid", out_valid, 64'd0);
        rst_n = 1'b1;
        model_step();
        run(12);
        for (int i = 0; i < 3; i++) begin
            check_val("seq_addr", log_at(addr_log, i), 64'(i * 4));
            check_val("seq_out_pc", log_at(pc_log, i), 64'(i * 4));
        end

        // Back-pressure: exactly DEPTH requests, then one more per dequeue.
        do_reset();
        rdy_pct = 0; lat_min = 1; lat_max = 3;
        run(40);
        check_val("bp_reqs", 64'(addr_log.size()), 64'(DEPTH));
        rdy_pct = 100;
        run(1);
        rdy_pct = 0;
        run(20);
        check_val("bp_reqs_plus1", 64'(addr_log.size()), 64'(DEPTH + 1));

        // Redirect while waiting; response 5 cycles later is dropped.
        do_reset();
        rdy_pct = 100; lat_min = 5; lat_max = 5;
        arm_pc = 64'h1002; arm_on_req = 1'b1;
        run(30);
        check_val("redir_next_addr", log_at(addr_log, 1), 64'h1000);
        check_val("redir_first_out", log_at(pc_log, 0), 64'h1000);

        // Redirect coincident with ic_valid while two entries are buffered.
        do_reset();
        rdy_pct = 0; lat_min = 1; lat_max = 1;
        run_until_reqs(3, 40);
        arm_pc = 64'h2000; arm_on_iv = 1'b1;
        run(10);
        check_val("redir_iv_addr", log_at(addr_log, 3), 64'h2000);
        rdy_pct = 100;
        run(10);
        check_val("redir_iv_out", log_at(pc_log, 0), 64'h2000);

        // Sequential fetch across the top of the address space.
        do_reset();
        rdy_pct = 100; lat_min = 1; lat_max = 1;
        arm_pc = 64'hFFFF_FFFF_FFFF_FFFE; arm_on_iv = 1'b1;
        run(12);
        check_val("wrap_addr_top", log_at(addr_log, 1), 64'hFFFF_FFFF_FFFF_FFFC);
        check_val("wrap_addr_zero", log_at(addr_log, 2), 64'h0);

        // Reset mid-request with the FIFO nearly full, then restart at RESET_PC.
        do_reset();
        rdy_pct = 0; lat_min = 6; lat_max = 6;
        run_until_reqs(DEPTH, 60);
        do_reset();
        rdy_pct = 100; lat_min = 1; lat_max = 2;
        run(6);
        check_val("rst_restart_addr", log_at(addr_log, 0), RESET_PC);

        // Random traffic: latencies, back-pressure, redirects, and near-wrap targets.
        do_reset();
        lat_min = 1; lat_max = 4; rdy_pct = 60; redir_pct = 8;
        redir_base = 64'($urandom) << 4;
        run(3000);
        rdy_pct = 20; redir_base = 64'hFFFF_FFFF_FFFF_FFE0;
        run(1000);
        redir_pct = 0; rdy_pct = 90;
        run(500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
